// File: rtl/pcie_tx_pkg.sv
// Shared definitions for the PCIe TX arbiter: FSM encoding, credit-field layout
// and the credit sufficiency test used when credit checking is compiled in.
package pcie_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_e;

    localparam int HCRED_W       = 9;
    localparam int DCRED_W       = 13;
    localparam int HCRED_INF_BIT = 8;
    localparam int DCRED_INF_BIT = 12;
    localparam int DNEED_W       = 8;

    // A set infinite bit satisfies the check regardless of the count field.
    function automatic logic credit_ok(
        input logic [HCRED_W-1:0] hcred,
        input logic [DCRED_W-1:0] dcred,
        input logic [DNEED_W-1:0] need
    );
        logic hdr_ok;
        logic dat_ok;
        hdr_ok = hcred[HCRED_INF_BIT] || (hcred[HCRED_INF_BIT-1:0] != '0);
        dat_ok = dcred[DCRED_INF_BIT] ||
                 (dcred[DCRED_INF_BIT-1:0] >= {{(DCRED_INF_BIT-DNEED_W){1'b0}}, need});
        return hdr_ok && dat_ok;
    endfunction

endpackage

// File: rtl/pcie_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module pcie_rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [IW-1:0] cand [N];
    logic [N-1:0]  hit;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [IW:0] sum;
            assign sum       = {1'b0, ptr} + (IW+1)'(gi);
            assign cand[gi]  = (sum >= N_W) ? IW'(sum - N_W) : sum[IW-1:0];
            assign hit[gi]   = elig[cand[gi]];
        end
    endgenerate

    // Scan from the far end so the candidate closest to ptr wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx   = cand[k];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_tx_arb.sv
// Round-robin TLP arbiter in front of the PCIe core TX port. Define
// PCIE_TX_CREDIT_CHK_EN to gate eligibility on available header/data credits.
module pcie_tx_arb
    import pcie_tx_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = 16
) (
    input  logic                 clk_125,
    input  logic                 sys_rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_posted,
    input  logic [NREQ*8-1:0]    req_dcred,
    output logic [NREQ-1:0]      gnt,
    input  logic [NREQ-1:0]      st_i,
    input  logic [NREQ-1:0]      end_i,
    input  logic [NREQ*DW-1:0]   data_i,
    output logic                 tx_req,
    input  logic                 tx_rdy,
    output logic                 tx_st,
    output logic                 tx_end,
    output logic [DW-1:0]        tx_data,
    input  logic [HCRED_W-1:0]   tx_ca_ph,
    input  logic [HCRED_W-1:0]   tx_ca_cplh,
    input  logic [DCRED_W-1:0]   tx_ca_pd,
    input  logic [DCRED_W-1:0]   tx_ca_cpld
);

    localparam int SW = $clog2(NREQ);
    localparam logic [SW-1:0] LAST_IDX = SW'(NREQ - 1);

    arb_state_e      state_reg, state_next;
    logic [SW-1:0]   sel_reg, sel_next;
    logic [SW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic            st_seen_reg, st_seen_next;
    logic [NREQ-1:0] elig;
    logic [SW-1:0]   pick_idx;
    logic            pick_valid;

`ifdef PCIE_TX_CREDIT_CHK_EN
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
            assign elig[gi] = req[gi] && (req_posted[gi]
                ? credit_ok(tx_ca_ph,   tx_ca_pd,   req_dcred[gi*8 +: 8])
                : credit_ok(tx_ca_cplh, tx_ca_cpld, req_dcred[gi*8 +: 8]));
        end
    endgenerate
`else
    logic unused_credit_inputs;
    assign unused_credit_inputs = ^{req_posted, req_dcred, tx_ca_ph, tx_ca_cplh,
                                    tx_ca_pd, tx_ca_cpld};
    assign elig = req;
`endif

    pcie_rr_pick #(
        .N  (NREQ),
        .IW (SW)
    ) u_pick (
        .elig  (elig),
        .ptr   (rr_ptr_reg),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            state_reg   <= ST_IDLE;
            sel_reg     <= '0;
            rr_ptr_reg  <= '0;
            st_seen_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            rr_ptr_reg  <= rr_ptr_next;
            st_seen_reg <= st_seen_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        rr_ptr_next  = rr_ptr_reg;
        st_seen_next = st_seen_reg;
        gnt          = '0;
        tx_req       = 1'b0;
        tx_st        = 1'b0;
        tx_end       = 1'b0;
        tx_data      = '0;
        case (state_reg)
            ST_IDLE: begin
                st_seen_next = 1'b0;
                if (pick_valid) begin
                    sel_next   = pick_idx;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                tx_req = 1'b1;
                // A withdrawn request abandons the slot without advancing rr_ptr.
                if (!req[sel_reg])
                    state_next = ST_IDLE;
                else if (tx_rdy)
                    state_next = ST_XFER;
            end
            ST_XFER: begin
                gnt[sel_reg] = 1'b1;
                tx_req       = !st_seen_reg;
                tx_st        = st_i[sel_reg];
                tx_end       = end_i[sel_reg];
                tx_data      = data_i[sel_reg*DW +: DW];
                if (st_i[sel_reg])
                    st_seen_next = 1'b1;
                if (end_i[sel_reg]) begin
                    state_next  = ST_IDLE;
                    rr_ptr_next = (sel_reg == LAST_IDX) ? '0 : sel_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
